// File: rtl/runner_pkg.sv
// runner_pkg: shared sprite-sheet and screen-position types for the runner game.
//   sprite_t : sprite-sheet rectangle {x, y, w, h}, 12 bits each (48 bits)
//   pos_t    : signed screen position {x, y}, 12 bits each (24 bits)
package runner_pkg;
    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] w;
        logic [11:0] h;
    } sprite_t;
    typedef struct packed {
        logic signed [11:0] x;
        logic signed [11:0] y;
    } pos_t;
endpackage

// File: rtl/sprite_table_pkg.sv
// sprite_table_pkg: render-slot entry type, slot index width helper and the empty entry.
package sprite_table_pkg;
    import runner_pkg::*;
    typedef struct packed {
        logic    valid;
        sprite_t sprite;
        pos_t    pos;
    } entry_t;
    localparam entry_t EMPTY_ENTRY = '0;
    function automatic int slot_width(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction
endpackage

// File: rtl/sprite_bank.sv
// sprite_bank: one bank of render slots with a prioritised multi-port write,
// a bulk valid clear and a registered read.
//   clk, rst              : clock, synchronous active-high reset (clears valids and read register)
//   we                    : bank write enable, gates all write ports
//   clr                   : clear every valid flag; same-cycle writes win over the clear
//   wr_en/slot/sprite/pos : producer write ports, lower index wins on a slot collision
//   rd_slot, rd_entry     : read address and registered entry (EMPTY_ENTRY when invalid)
module sprite_bank import runner_pkg::*, sprite_table_pkg::*; #(
    parameter int SLOTS = 32,
    parameter int WRITE_PORTS = 2,
    parameter int SLOT_W = slot_width(SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              clr,
    input  logic              wr_en     [WRITE_PORTS],
    input  logic [SLOT_W-1:0] wr_slot   [WRITE_PORTS],
    input  sprite_t           wr_sprite [WRITE_PORTS],
    input  pos_t              wr_pos    [WRITE_PORTS],
    input  logic [SLOT_W-1:0] rd_slot,
    output entry_t            rd_entry
);
    logic [SLOTS-1:0] valid;
    sprite_t sprite_mem [SLOTS];
    pos_t    pos_mem    [SLOTS];
    function automatic logic in_range(input logic [SLOT_W-1:0] s);
        return {1'b0, s} < (SLOT_W+1)'(SLOTS);
    endfunction
    // Ports are applied from highest index down so the lowest index lands last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            rd_entry <= EMPTY_ENTRY;
        end else begin
            rd_entry <= (in_range(rd_slot) && valid[rd_slot])
                ? entry_t'{1'b1, sprite_mem[rd_slot], pos_mem[rd_slot]} : EMPTY_ENTRY;
            if (clr) valid <= '0;
            for (int p = WRITE_PORTS - 1; p >= 0; p--) begin
                if (we && wr_en[p] && in_range(wr_slot[p])) begin
                    valid[wr_slot[p]]      <= 1'b1;
                    sprite_mem[wr_slot[p]] <= wr_sprite[p];
                    pos_mem[wr_slot[p]]    <= wr_pos[p];
                end
            end
        end
    end
endmodule

// File: rtl/sprite_table.sv
// sprite_table: double-buffered render-slot table between game logic and painter.
// A rising edge of painter_finished swaps banks, clears the new shadow bank's
// valids, pulses update and advances timer (mod FPS).
// Macro SPRITE_TABLE_DOUBLE_BUFFER_EN selects two banks; undefined gives a
// single bank whose writes are readable right away and cleared on each swap.
//   clk, rst                      : clock, synchronous active-high reset
//   wr_en/slot/sprite/pos         : producer write ports, lower index has priority
//   painter_finished              : painter frame-done level
//   rd_slot                       : painter read address
//   rd_sprite, rd_pos, rd_valid   : registered active entry (zero when invalid)
//   update                        : one-cycle game-step pulse after each swap
//   timer                         : frame counter 0..FPS-1
module sprite_table import runner_pkg::*, sprite_table_pkg::*; #(
    parameter int SLOTS = 32,
    parameter int WRITE_PORTS = 2,
    parameter int FPS = 60,
    parameter int SLOT_W = slot_width(SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en     [WRITE_PORTS],
    input  logic [SLOT_W-1:0] wr_slot   [WRITE_PORTS],
    input  sprite_t           wr_sprite [WRITE_PORTS],
    input  pos_t              wr_pos    [WRITE_PORTS],
    input  logic              painter_finished,
    input  logic [SLOT_W-1:0] rd_slot,
    output sprite_t           rd_sprite,
    output pos_t              rd_pos,
    output logic              rd_valid,
    output logic              update,
    output logic [5:0]        timer
);
    logic   painter_finished_last;
    logic   swap;
    entry_t rd_entry;
    assign swap = painter_finished & ~painter_finished_last;
    always_ff @(posedge clk) begin
        if (rst) begin
            painter_finished_last <= 1'b0;
            update                <= 1'b0;
            timer                 <= '0;
        end else begin
            painter_finished_last <= painter_finished;
            update                <= swap;
            if (swap) timer <= (timer == 6'(FPS - 1)) ? '0 : timer + 6'd1;
        end
    end
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
    logic   sel;
    logic   rd_sel;
    entry_t rd_entry0;
    entry_t rd_entry1;
    // Outside a swap the shadow (~sel) is written; in a swap cycle the old
    // active bank (sel) becomes the shadow, so it takes both the clear and the writes.
    // rd_sel remembers which bank the registered read came from.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel    <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            rd_sel <= sel;
            if (swap) sel <= ~sel;
        end
    end
    sprite_bank #(.SLOTS(SLOTS), .WRITE_PORTS(WRITE_PORTS), .SLOT_W(SLOT_W)) bank0 (
        .clk(clk), .rst(rst), .we(sel ^ swap), .clr(swap & ~sel),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_sprite(wr_sprite), .wr_pos(wr_pos),
        .rd_slot(rd_slot), .rd_entry(rd_entry0)
    );
    sprite_bank #(.SLOTS(SLOTS), .WRITE_PORTS(WRITE_PORTS), .SLOT_W(SLOT_W)) bank1 (
        .clk(clk), .rst(rst), .we(~(sel ^ swap)), .clr(swap & sel),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_sprite(wr_sprite), .wr_pos(wr_pos),
        .rd_slot(rd_slot), .rd_entry(rd_entry1)
    );
    assign rd_entry = rd_sel ? rd_entry1 : rd_entry0;
`else
    sprite_bank #(.SLOTS(SLOTS), .WRITE_PORTS(WRITE_PORTS), .SLOT_W(SLOT_W)) bank0 (
        .clk(clk), .rst(rst), .we(1'b1), .clr(swap),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_sprite(wr_sprite), .wr_pos(wr_pos),
        .rd_slot(rd_slot), .rd_entry(rd_entry)
    );
`endif
    assign rd_sprite = rd_entry.sprite;
    assign rd_pos    = rd_entry.pos;
    assign rd_valid  = rd_entry.valid;
endmodule

// File: tb/tb_sprite_table.sv
// tb_sprite_table: directed and randomized checks of sprite_table against a frame-level model.
module tb_sprite_table;
    import runner_pkg::*;
    import sprite_table_pkg::*;
    localparam int SLOTS = 32;
    localparam int WP = 2;
    localparam int FPS = 60;
    logic       clk = 1'b0;
    logic       rst;
    logic       pf;
    logic       wr_en     [WP];
    logic [4:0] wr_slot   [WP];
    sprite_t    wr_sprite [WP];
    pos_t       wr_pos    [WP];
    logic [4:0] rd_slot;
    sprite_t    rd_sprite;
    pos_t       rd_pos;
    logic       rd_valid;
    logic       update;
    logic [5:0] timer;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    sprite_table dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_slot(wr_slot), .wr_sprite(wr_sprite),
        .wr_pos(wr_pos), .painter_finished(pf), .rd_slot(rd_slot), .rd_sprite(rd_sprite),
        .rd_pos(rd_pos), .rd_valid(rd_valid), .update(update), .timer(timer)
    );
    task automatic check(input string n, input logic [72:0] a, input logic [72:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    // Frame-level model: pend holds what producers wrote for the coming frame,
    // act holds what the painter sees. Invalid entries are kept all-zero.
    entry_t pend [SLOTS];
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
    entry_t act [SLOTS];
`endif
    logic   m_pf_last;
    int     m_timer;
    entry_t exp_rd = '0;
    logic   exp_upd = 1'b0;
    int     exp_timer = 0;
    always @(posedge clk) begin : model
        logic sw;
        logic taken [SLOTS];
        if (rst) begin
            foreach (pend[i]) pend[i] = '0;
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
            foreach (act[i]) act[i] = '0;
`endif
            m_pf_last = 1'b0;
            m_timer = 0;
            exp_rd = '0;
            exp_upd = 1'b0;
            exp_timer = 0;
        end else begin
            sw = pf && !m_pf_last;
            m_pf_last = pf;
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
            exp_rd = act[rd_slot];
            if (sw) begin
                act = pend;
                foreach (pend[i]) pend[i] = '0;
            end
`else
            exp_rd = pend[rd_slot];
            if (sw) foreach (pend[i]) pend[i] = '0;
`endif
            exp_upd = sw;
            if (sw) m_timer = (m_timer + 1) % FPS;
            exp_timer = m_timer;
            foreach (taken[i]) taken[i] = 1'b0;
            for (int p = 0; p < WP; p++) begin
                if (wr_en[p] && !taken[wr_slot[p]]) begin
                    taken[wr_slot[p]] = 1'b1;
                    pend[wr_slot[p]] = '{1'b1, wr_sprite[p], wr_pos[p]};
                end
            end
        end
    end
    always @(negedge clk) begin
        check("rd_entry", {rd_valid, rd_sprite, rd_pos}, exp_rd);
        check("update", 73'(update), 73'(exp_upd));
        check("timer", 73'(timer), 73'(exp_timer));
    end
    logic [72:0] snap1;
    logic [72:0] snap2;
    task automatic tick;
        @(negedge clk);
    endtask
    task automatic idle;
        foreach (wr_en[i]) wr_en[i] = 1'b0;
    endtask
    task automatic wr(input int p, input int s, input sprite_t sp, input pos_t ps);
        wr_en[p] = 1'b1;
        wr_slot[p] = 5'(s);
        wr_sprite[p] = sp;
        wr_pos[p] = ps;
    endtask
    task automatic swap_pulse;
        pf = 1'b1;
        tick;
        snap1 = {rd_valid, rd_sprite, rd_pos};
        check("upd_pulse", 73'(update), 73'(1));
        idle;
        pf = 1'b0;
        tick;
        snap2 = {rd_valid, rd_sprite, rd_pos};
        check("upd_off", 73'(update), 73'(0));
    endtask
    initial begin
        sprite_t s18, sa, sb, sx;
        pos_t    p18, pa, pb, px;
        int      cnt;
        s18 = '{12'd1678, 12'd2, 12'd88, 12'd94};
        p18 = '{12'sd100, 12'sd186};
        sa = '{12'd111, 12'd5, 12'd6, 12'd7};
        sb = '{12'd222, 12'd5, 12'd6, 12'd7};
        pa = '{12'sd10, -12'sd20};
        pb = '{12'sd30, 12'sd40};
        sx = '{12'd9, 12'd8, 12'd7, 12'd6};
        px = '{-12'sd1, 12'sd2};
        rst = 1'b1;
        pf = 1'b0;
        rd_slot = '0;
        foreach (wr_slot[i]) begin
            wr_slot[i] = '0;
            wr_sprite[i] = '0;
            wr_pos[i] = '0;
        end
        idle;
        tick;
        tick;
        rst = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            rd_slot = 5'(s);
            tick;
            check("empty_valid", 73'(rd_valid), 73'(0));
            check("empty_sprite", 73'(rd_sprite), 73'(0));
        end
        check("reset_update", 73'(update), 73'(0));
        check("reset_timer", 73'(timer), 73'(0));
        wr(0, 18, s18, p18);
        rd_slot = 5'd18;
        tick;
        idle;
        check("pre18_a", 73'(rd_valid), 73'(0));
        tick;
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
        check("pre18_b", 73'(rd_valid), 73'(0));
        swap_pulse;
        check("post18", snap2, {1'b1, s18, p18});
`else
        check("single18", {rd_valid, rd_sprite, rd_pos}, {1'b1, s18, p18});
        swap_pulse;
        check("single18_clr", snap2, 73'(0));
`endif
        wr(0, 11, sa, pa);
        wr(1, 11, sb, pb);
        rd_slot = 5'd11;
        tick;
        idle;
        swap_pulse;
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
        check("prio11", snap2, {1'b1, sa, pa});
`else
        check("prio11", snap1, {1'b1, sa, pa});
`endif
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int k = 0; k < FPS; k++) begin
            swap_pulse;
            check("timer_seq", 73'(timer), 73'((k + 1) % FPS));
        end
        pf = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            cnt += int'(update);
        end
        pf = 1'b0;
        tick;
        cnt += int'(update);
        check("held_pulses", 73'(cnt), 73'(1));
        rd_slot = 5'd4;
        wr(0, 4, sx, px);
        tick;
        idle;
        swap_pulse;
        swap_pulse;
        check("stale4", 73'(snap2[72]), 73'(0));
        rd_slot = 5'd5;
        wr(1, 5, sx, px);
        swap_pulse;
`ifndef SPRITE_TABLE_DOUBLE_BUFFER_EN
        check("swap_write5", snap2, {1'b1, sx, px});
`endif
        swap_pulse;
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
        check("swap_write5", snap2, {1'b1, sx, px});
`endif
        pf = 1'b0;
        tick;
        pf = 1'b1;
        rst = 1'b1;
        tick;
        check("rst_swap_upd", 73'(update), 73'(0));
        check("rst_swap_timer", 73'(timer), 73'(0));
        check("rst_swap_rd", {rd_valid, rd_sprite, rd_pos}, 73'(0));
        rst = 1'b0;
        pf = 1'b0;
        tick;
        check("rst_swap_upd2", 73'(update), 73'(0));
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) pf = ~pf;
            rd_slot = 5'($urandom_range(0, SLOTS - 1));
            for (int p = 0; p < WP; p++) begin
                wr_en[p] = $urandom_range(0, 1) == 1;
                wr_slot[p] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                          : 5'($urandom_range(0, SLOTS - 1));
                wr_sprite[p] = 48'({$urandom(), $urandom()});
                wr_pos[p] = 24'($urandom());
            end
            tick;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_table.md
# sprite_table

Double-buffered render-slot table between the game logic and the painter. It generalises the per-slot sprite/pos output array to a parametrised slot count, several prioritised write ports, and a frame-synchronous bank swap. Producers (trex, horizon, distance meter, game-over panel) write entries into the shadow bank during a frame. The painter reads the active bank through a registered read port. Each rising edge of `painter_finished` swaps the banks and emits the game-loop `update` pulse and frame timer.

## Interface
- `SLOTS`, default 32: number of render slots; `SLOT_W = $clog2(SLOTS)`.
- `WRITE_PORTS`, default 2: independent producer write ports; lower index has higher priority.
- `FPS`, default 60: modulus of `timer`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `wr_en[WRITE_PORTS]`  in  1 each: write strobe.
- `wr_slot[WRITE_PORTS]`  in  SLOT_W each: target slot.
- `wr_sprite[WRITE_PORTS]`  in  sprite_t (48): sprite-sheet x, y, w, h.
- `wr_pos[WRITE_PORTS]`  in  pos_t (24): signed screen x, y.
- `painter_finished`  in  1: level from the painter; high once the frame is drawn.
- `rd_slot`  in  SLOT_W: painter read address.
- `rd_sprite`  out  sprite_t: entry sprite, or zero if the slot is invalid.
- `rd_pos`  out  pos_t: entry position, or zero if the slot is invalid.
- `rd_valid`  out  1: slot holds an entry written this frame.
- `update`  out  1: one-cycle game-step pulse.
- `timer`  out  6: frame counter, 0..FPS-1.

## Operation
- Storage: two banks of SLOTS entries {valid, sprite_t, pos_t}. `sel` names the active bank; the shadow bank is `~sel`.
- Writes: every cycle, each port with `wr_en` writes the shadow entry at `wr_slot` and sets its valid flag.
  - If two ports hit the same slot, the lowest port index wins; the others are dropped silently.
  - `wr_slot >= SLOTS` is ignored.
- Swap: a rising edge of `painter_finished` (registered `painter_finished_last`) is a swap cycle. At the clock edge ending that cycle:
  - `sel` toggles.
  - All valid flags of the new shadow bank (the old active bank) clear.
  - `update` is set to 1 for exactly one cycle.
  - `timer` advances to `timer+1`, or to 0 when `timer+1 == FPS`.
- Write in a swap cycle: it targets the new shadow bank, i.e. the bank indexed by the old `sel`. The write wins over the clear for that slot, so the entry survives.
- Read: `rd_*` are registered from active bank entry `rd_slot`. If the entry is invalid, or `rd_slot >= SLOTS`, then `rd_sprite = 0`, `rd_pos = 0` and `rd_valid = 0`.
- Producers rewrite every slot they own every frame. Unwritten slots read as empty, which matches the zero-sprite convention.

## Timing
- Reset values:
  - `sel = 0`, `painter_finished_last = 0`.
  - All valid flags in both banks are 0.
  - `rd_sprite = 0`, `rd_pos = 0`, `rd_valid = 0`, `update = 0`, `timer = 0`.
  - Reset applies mid-frame and mid-swap: it overrides any write, swap or `update` in the same cycle.
- Read latency: 1 cycle, from `rd_slot` to `rd_*`.
- Write-to-visible latency: a write is readable only after the next swap. The read issued in the cycle after the swap edge returns it.
- `update` is high in the cycle immediately after the swap cycle. `painter_finished` held high produces no further pulses. A low→high transition on consecutive cycles is impossible, since at least one low cycle is required between edges.
- A swap in the same cycle as a read: the read samples the pre-swap active bank, because the read registers on the old `sel`.

## Configuration
- `SPRITE_TABLE_DOUBLE_BUFFER_EN` defined: two banks, behaviour as above.
- Macro undefined: single bank, no `sel`.
  - Writes land in the one bank and are readable 1 cycle after the write (2 cycles after `wr_en`, `rd_slot` matching).
  - On the swap cycle all valid flags clear, except slots written in that same cycle.
  - `update` and `timer` behave identically in both modes.

## Structure
- Package `sprite_table_pkg`:
  - `entry_t` = {valid, sprite_t, pos_t}, reusing `runner_pkg::sprite_t` and `runner_pkg::pos_t`.
  - Function `slot_width(SLOTS)`.
  - Zero constant `EMPTY_ENTRY`.
- Sub-module `sprite_bank`: one bank with a priority multi-port write, a bulk valid clear, a write-beats-clear rule and a registered read. `sprite_table` instantiates it once or twice under the macro, plus the edge detector, `sel` and `timer` logic.

## Test plan
- Reset, then read slots 0..31 → all `rd_valid = 0` and `rd_sprite = 0`; `update = 0`; `timer = 0`.
- Port 0 writes slot 18 = {1678, 2, 88, 94} / {100, 186}, then `painter_finished` 0→1 → `update` pulses 1 cycle; the read of slot 18 returns that entry; before the swap it returned invalid.
- Port 0 and port 1 write slot 11 in the same cycle with different x, then swap → port 0's data is read.
- 60 swaps → `timer` goes 0..59, back to 0; `painter_finished` held high 10 cycles → exactly one `update`.
- Frame N writes slot 4, frame N+1 does not, then two swaps → slot 4 is invalid. A write to slot 5 during the swap cycle → slot 5 is valid after the following swap.
- With the macro undefined: write slot 2, read 2 cycles later → valid, with no swap needed.
- Assert `rst` in a swap cycle → `update` stays 0 and all outputs return to reset values.
